// File: rtl/eq_pkg.sv
// Shared constants, FSM state type and fixed-point helpers for the biquad equalizer.
package eq_pkg;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int ACC_W     = 40;
    localparam int FRAC_BITS = 14;
    localparam int N_SECT    = 3;
    localparam int N_TAPS    = 5;
    localparam int N_COEF    = N_SECT * N_TAPS;

    // Tap order inside a section; a1/a2 are stored pre-negated.
    localparam int TAP_B0 = 0;
    localparam int TAP_B1 = 1;
    localparam int TAP_B2 = 2;
    localparam int TAP_A1 = 3;
    localparam int TAP_A2 = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Unity passthrough: b0 = 1.0 in Q2.14, everything else zero.
    localparam logic [COEF_W-1:0] COEF_RST_B0    = 16'h4000;
    localparam logic [COEF_W-1:0] COEF_RST_OTHER = 16'h0000;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

    function automatic logic [COEF_W-1:0] coef_rst_value(input int idx);
        return ((idx % N_TAPS) == TAP_B0) ? COEF_RST_B0 : COEF_RST_OTHER;
    endfunction

    // Drop the fraction bits (arithmetic shift, truncation) and clamp to 16 bits.
    function automatic logic [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC_BITS;
        if (sh > SAT_MAX) begin
            return 16'h7FFF;
        end else if (sh < SAT_MIN) begin
            return 16'h8000;
        end
        return sh[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/eq_coef_bank.sv
// Double-buffered coefficient store: host writes land in the shadow bank and are
// copied to the active bank only when a sample is accepted with a commit pending.
module eq_coef_bank
    import eq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_addr_i,
    input  logic [COEF_W-1:0] wr_data_i,
    input  logic              commit_i,
    input  logic              apply_i,
    input  logic [1:0]        rd_sect_i,
    input  logic [2:0]        rd_tap_i,
    output logic [COEF_W-1:0] rd_data_o
);

    logic [COEF_W-1:0] shadow_q [N_COEF];
    logic [COEF_W-1:0] active_q [N_COEF];
    logic              pending_q;
    logic              pending_d;
    logic              do_copy;
    logic [3:0]        rd_idx;

    assign do_copy = apply_i && pending_q;

    // A commit arriving in the same cycle as an apply stays pending for the next sample.
    always_comb begin
        pending_d = pending_q;
        if (apply_i) begin
            pending_d = 1'b0;
        end
        if (commit_i) begin
            pending_d = 1'b1;
        end
    end

    // Commit-pending flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // One shadow/active pair per coefficient; address 15 matches no entry and is ignored.
    generate
        for (genvar gi = 0; gi < N_COEF; gi++) begin : g_coef
            localparam logic [COEF_W-1:0] RST_VAL = coef_rst_value(gi);

            // Shadow takes host writes; active copies shadow on an applied commit.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    shadow_q[gi] <= RST_VAL;
                    active_q[gi] <= RST_VAL;
                end else begin
                    if (wr_en_i && (wr_addr_i == 4'(gi))) begin
                        shadow_q[gi] <= wr_data_i;
                    end
                    if (do_copy) begin
                        active_q[gi] <= shadow_q[gi];
                    end
                end
            end
        end
    endgenerate

    assign rd_idx = 4'(rd_sect_i) * 4'd5 + 4'(rd_tap_i);

    // Combinational read of the active coefficient for the current (section, tap).
    always_comb begin
        rd_data_o = '0;
        if (rd_idx < 4'(N_COEF)) begin
            rd_data_o = active_q[rd_idx];
        end
    end

endmodule

// File: rtl/eq_biquad_scheduler.sv
// Three-section stereo biquad cascade sharing one 16x16 multiplier and a 40-bit
// accumulator; one sample per l_r_clk edge, 19 busy cycles per sample.
module eq_biquad_scheduler
    import eq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              l_r_clk,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              coef_wr_en,
    input  logic [3:0]        coef_wr_addr,
    input  logic [COEF_W-1:0] coef_wr_data,
    input  logic              coef_commit,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_ch,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    logic lr_sync1_q, lr_sync2_q, lr_prev_q;
    logic edge_pulse, accept;

    state_e      state_q, state_d;
    logic [1:0]  sect_q, sect_d;
    logic [2:0]  tap_q, tap_d;
    logic        last_sect;

    logic                     ch_q;
    logic [DATA_W-1:0]        x0_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]        x1_q [2][N_SECT];
    logic [DATA_W-1:0]        x2_q [2][N_SECT];
    logic [DATA_W-1:0]        y1_q [2][N_SECT];
    logic [DATA_W-1:0]        y2_q [2][N_SECT];
    logic [DATA_W-1:0]        sample_out_q;
    logic                     sample_out_ch_q;
    logic                     overrun_q;

    logic [COEF_W-1:0]        coef_rd;
    logic [DATA_W-1:0]        operand;
    logic signed [31:0]       prod;
    logic [DATA_W-1:0]        y_wb;

    assign edge_pulse = lr_sync2_q ^ lr_prev_q;
    assign accept     = edge_pulse && (state_q == IDLE);
    assign last_sect  = (sect_q == 2'(N_SECT - 1));

    eq_coef_bank u_coef_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (coef_wr_en),
        .wr_addr_i (coef_wr_addr),
        .wr_data_i (coef_wr_data),
        .commit_i  (coef_commit),
        .apply_i   (accept),
        .rd_sect_i (sect_q),
        .rd_tap_i  (tap_q),
        .rd_data_o (coef_rd)
    );

    // Two-flop synchronizer for l_r_clk plus the previous synced level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lr_sync1_q <= 1'b0;
            lr_sync2_q <= 1'b0;
            lr_prev_q  <= 1'b0;
        end else begin
            lr_sync1_q <= l_r_clk;
            lr_sync2_q <= lr_sync1_q;
            lr_prev_q  <= lr_sync2_q;
        end
    end

    // FSM state register with section and tap counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sect_q  <= '0;
            tap_q   <= '0;
        end else begin
            state_q <= state_d;
            sect_q  <= sect_d;
            tap_q   <= tap_d;
        end
    end

    // Next-state: five MAC taps, one write-back per section, one DONE cycle at the end.
    always_comb begin
        state_d = state_q;
        sect_d  = sect_q;
        tap_d   = tap_q;
        case (state_q)
            IDLE: begin
                if (edge_pulse) begin
                    state_d = MAC;
                    sect_d  = '0;
                    tap_d   = '0;
                end
            end
            MAC: begin
                if (tap_q == 3'(N_TAPS - 1)) begin
                    state_d = WB;
                end else begin
                    tap_d = tap_q + 3'd1;
                end
            end
            WB: begin
                tap_d = '0;
                if (last_sect) begin
                    state_d = DONE;
                end else begin
                    sect_d  = sect_q + 2'd1;
                    state_d = MAC;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    // Operand for the current tap, taken from the active channel's state slice.
    always_comb begin
        operand = x0_q;
        case (tap_q)
            3'(TAP_B0): operand = x0_q;
            3'(TAP_B1): operand = x1_q[ch_q][sect_q];
            3'(TAP_B2): operand = x2_q[ch_q][sect_q];
            3'(TAP_A1): operand = y1_q[ch_q][sect_q];
            3'(TAP_A2): operand = y2_q[ch_q][sect_q];
            default:    operand = x0_q;
        endcase
    end

    assign prod = $signed(coef_rd) * $signed(operand);
    assign y_wb = sat16(acc_q);

    // Tap 0 restarts the sum so no explicit clear cycle is needed between sections.
    always_comb begin
        acc_d = (tap_q == 3'(TAP_B0)) ? '0 : acc_q;
        acc_d = acc_d + {{(ACC_W-32){prod[31]}}, prod};
    end

    // Datapath: capture, accumulate, write-back and filter-state shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q            <= 1'b0;
            x0_q            <= '0;
            acc_q           <= '0;
            sample_out_q    <= '0;
            sample_out_ch_q <= 1'b0;
            overrun_q       <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                for (int s = 0; s < N_SECT; s++) begin
                    x1_q[c][s] <= '0;
                    x2_q[c][s] <= '0;
                    y1_q[c][s] <= '0;
                    y2_q[c][s] <= '0;
                end
            end
        end else begin
            if (accept) begin
                x0_q <= sample_in;
                ch_q <= lr_sync2_q;
            end else if (edge_pulse) begin
                overrun_q <= 1'b1;
            end
            if (state_q == MAC) begin
                acc_q <= acc_d;
            end
            if (state_q == WB) begin
                x2_q[ch_q][sect_q] <= x1_q[ch_q][sect_q];
                x1_q[ch_q][sect_q] <= x0_q;
                y2_q[ch_q][sect_q] <= y1_q[ch_q][sect_q];
                y1_q[ch_q][sect_q] <= y_wb;
                if (!last_sect) begin
                    x0_q <= y_wb;
                end else begin
                    // Loaded as the last write-back retires so it is valid during DONE.
                    sample_out_q    <= y_wb;
                    sample_out_ch_q <= ch_q;
                end
            end
        end
    end

    assign sample_out    = sample_out_q;
    assign sample_out_ch = sample_out_ch_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_eq_biquad_scheduler.sv
// Directed bench for eq_biquad_scheduler: table of samples with hand-computed outputs
// plus hand-written sequences for commit timing, overrun and mid-sample reset.
module tb_eq_biquad_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        l_r_clk = 1'b0;
    logic [15:0] sample_in = '0;
    logic        coef_wr_en = 1'b0;
    logic [3:0]  coef_wr_addr = '0;
    logic [15:0] coef_wr_data = '0;
    logic        coef_commit = 1'b0;
    logic [15:0] sample_out;
    logic        sample_out_ch;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int tests = 0;
    int fails = 0;

    eq_biquad_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .l_r_clk       (l_r_clk),
        .sample_in     (sample_in),
        .coef_wr_en    (coef_wr_en),
        .coef_wr_addr  (coef_wr_addr),
        .coef_wr_data  (coef_wr_data),
        .coef_commit   (coef_commit),
        .sample_out    (sample_out),
        .sample_out_ch (sample_out_ch),
        .out_valid     (out_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          setup;   // 0 none, 1 reset, 2 reset + s0 a1=0.5, 3 reset + b0=0x7FFF all
        logic [15:0] din;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        l_r_clk      = 1'b0;
        coef_wr_en   = 1'b0;
        coef_commit  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sample_out", 32'(sample_out), 32'h0);
        check("rst_out_ch", 32'(sample_out_ch), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr_coef(input logic [3:0] a, input logic [15:0] d, input bit we, input bit cm);
        coef_wr_en   = we;
        coef_wr_addr = a;
        coef_wr_data = d;
        coef_commit  = cm;
        @(negedge clk);
        coef_wr_en   = 1'b0;
        coef_commit  = 1'b0;
    endtask

    // Toggle l_r_clk and follow one sample; commit_k/reset_k inject a commit pulse or a
    // reset at cycle E+k (0 = none).
    task automatic run_sample(input logic [15:0] din, input logic [15:0] dexp,
                              input int commit_k, input int reset_k);
        int n, nbusy, nvalid, vcyc;
        logic [15:0] vout;
        logic vch, exp_ch;
        sample_in = din;
        l_r_clk   = ~l_r_clk;
        exp_ch    = l_r_clk;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 8);
        check("busy_rise", 32'(busy), 32'h1);
        nbusy = 0; nvalid = 0; vcyc = 0; vout = '0; vch = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (busy) nbusy++;
            if (out_valid) begin
                nvalid++;
                vcyc = k;
                vout = sample_out;
                vch  = sample_out_ch;
            end
            coef_commit = (k == commit_k);
            if (k == reset_k) reset = 1'b1;
            @(negedge clk);
        end
        coef_commit = 1'b0;
        if (reset_k == 0) begin
            check("busy_cycles", 32'(nbusy), 32'd19);
            check("valid_pulses", 32'(nvalid), 32'd1);
            check("valid_cycle", 32'(vcyc), 32'd19);
            check("sample_out", 32'(vout), 32'(dexp));
            check("sample_out_ch", 32'(vch), 32'(exp_ch));
            $display("[TB] sample in=%h ch=%0d out=%h expected=%h", din, exp_ch, vout, dexp);
        end else begin
            check("abort_valid_pulses", 32'(nvalid), 32'd0);
            check("abort_busy", 32'(busy), 32'h0);
            check("abort_sample_out", 32'(sample_out), 32'h0);
            $display("[TB] sample in=%h aborted by reset at E+%0d, pulses=%0d", din, reset_k, nvalid);
            l_r_clk = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int nvalid;
        logic [15:0] vout;

        vecs[0] = '{1, 16'h1234, 16'h1234};   // unity passthrough after reset
        vecs[1] = '{2, 16'h0000, 16'h0000};   // right channel zero
        vecs[2] = '{0, 16'h1000, 16'h1000};   // left impulse
        vecs[3] = '{0, 16'h0000, 16'h0000};   // right stays zero
        vecs[4] = '{0, 16'h0000, 16'h0800};   // left decays by 0.5
        vecs[5] = '{0, 16'h0000, 16'h0000};
        vecs[6] = '{0, 16'h0000, 16'h0400};
        vecs[7] = '{3, 16'h7FFF, 16'h7FFF};   // positive clamp
        vecs[8] = '{0, 16'h8000, 16'h8000};   // negative clamp
        vecs[9] = '{0, 16'h0100, 16'h07F9};   // 0x100 -> 0x1FF -> 0x3FD -> 0x7F9 (truncation)

        for (int i = 0; i < 10; i++) begin
            case (vecs[i].setup)
                1: do_reset();
                2: begin
                    do_reset();
                    wr_coef(4'd3, 16'h2000, 1'b1, 1'b1);
                end
                3: begin
                    do_reset();
                    wr_coef(4'd0, 16'h7FFF, 1'b1, 1'b0);
                    wr_coef(4'd5, 16'h7FFF, 1'b1, 1'b0);
                    wr_coef(4'd10, 16'h7FFF, 1'b1, 1'b1);
                end
                default: ;
            endcase
            run_sample(vecs[i].din, vecs[i].dout, 0, 0);
        end

        // Commit: write then commit; a later uncommitted write has no effect.
        do_reset();
        wr_coef(4'd0, 16'h2000, 1'b1, 1'b0);
        wr_coef(4'd0, 16'h0000, 1'b0, 1'b1);
        run_sample(16'h4000, 16'h2000, 0, 0);
        wr_coef(4'd0, 16'h1000, 1'b1, 1'b0);
        run_sample(16'h4000, 16'h2000, 0, 0);
        wr_coef(4'd0, 16'h0000, 1'b0, 1'b1);
        run_sample(16'h4000, 16'h1000, 0, 0);
        wr_coef(4'd15, 16'h7FFF, 1'b1, 1'b1);
        run_sample(16'h4000, 16'h1000, 0, 0);

        // Overrun: second toggle 10 cycles after the first is dropped.
        do_reset();
        sample_in = 16'h0100;
        l_r_clk   = 1'b1;
        repeat (10) @(negedge clk);
        l_r_clk   = 1'b0;
        nvalid = 0;
        vout   = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                nvalid++;
                vout = sample_out;
            end
        end
        check("ovr_valid_pulses", 32'(nvalid), 32'd1);
        check("ovr_sample_out", 32'(vout), 32'h0100);
        check("ovr_flag", 32'(overrun), 32'h1);
        $display("[TB] overrun sequence pulses=%0d out=%h overrun=%0d", nvalid, vout, overrun);
        run_sample(16'h0200, 16'h0200, 0, 0);
        check("ovr_sticky", 32'(overrun), 32'h1);

        // Deferred commit, then reset abort restoring passthrough.
        do_reset();
        wr_coef(4'd0, 16'h2000, 1'b1, 1'b0);
        run_sample(16'h4000, 16'h4000, 5, 0);
        run_sample(16'h4000, 16'h2000, 0, 0);
        run_sample(16'h4000, 16'h0000, 0, 8);
        run_sample(16'h1234, 16'h1234, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eq_biquad_scheduler.md
# eq_biquad_scheduler

Time-multiplexed controller that runs the three cascaded biquad sections of the equalizer through one shared 16x16 multiplier and accumulator. It processes one sample per `l_r_clk` edge and keeps separate filter state for the left and right channels. It also owns a double-buffered coefficient bank with atomic commit, so a host can retune the EQ without glitches. It sits between the I2S receive path and the I2S transmit path.

## Interface
- `N_SECT`, 3, number of cascaded biquad sections.
- `DATA_W`, 16, sample width, signed.
- `COEF_W`, 16, coefficient width, signed Q2.14.
- `ACC_W`, 40, accumulator width, signed.
- `clk` in 1: high-speed system clock.
- `reset` in 1: asynchronous, active-high.
- `l_r_clk` in 1: asynchronous to `clk`. Every edge starts a new sample. The synced level after the edge is the channel (0 = left, 1 = right).
- `sample_in` in DATA_W: must be stable from the `l_r_clk` edge until capture.
- `coef_wr_en` in 1: writes `coef_wr_data` into the shadow bank.
- `coef_wr_addr` in 4: value is section*5 + tap, with taps 0..4 = b0, b1, b2, a1, a2. Address 15 is ignored.
- `coef_wr_data` in COEF_W: coefficient value.
- `coef_commit` in 1: one-cycle pulse that requests shadow→active copy.
- `sample_out` out DATA_W: last completed output sample.
- `sample_out_ch` out 1: channel of `sample_out`.
- `out_valid` out 1: one-cycle pulse when `sample_out` updates.
- `busy` out 1: high while a sample is being processed.
- `overrun` out 1: sticky flag; set when an edge arrives while busy.

## Operation
- `l_r_clk` passes through a 2-FF synchronizer and is compared with the previous synced value; any change produces `edge_pulse` in cycle E.
- Cycle E, not busy:
  - capture `sample_in` and the channel;
  - if a commit is pending, copy shadow→active and clear the pending bit;
  - go to MAC with section s=0 and tap t=0.
- Cycle E, busy: drop the edge and set `overrun`. No state is changed.
- States:
  - IDLE → MAC on an accepted edge.
  - MAC: 5 cycles, t=0..4. Each cycle does acc += coef[s][t]*operand[t], with operands x0, x1[ch][s], x2[ch][s], y1[ch][s], y2[ch][s]. acc is cleared at t=0.
  - MAC → WB after t=4.
  - WB, 1 cycle: y = sat16(acc >>> 14), using arithmetic shift, truncation, and clamp to [-32768, 32767]. Then shift state: x2←x1, x1←x0, y2←y1, y1←y. For s<N_SECT-1, x0←y, s++, go to MAC. Otherwise go to DONE.
  - DONE, 1 cycle: `sample_out`←y, `sample_out_ch`←ch, pulse `out_valid`, go to IDLE.
- Transfer function: y = b0·x0 + b1·x1 + b2·x2 + a1·y1 + a2·y2. The a-coefficients are stored pre-negated, so there is no subtraction in hardware.
- Products are 32-bit and sign-extended to ACC_W. With ACC_W=40 there is no intermediate overflow.
- Shadow writes are accepted in any state.
- `coef_commit` sets the pending bit. A commit is never applied mid-sample. A write and a commit in the same cycle include that write in the commit.
- Filter state for the two channels is fully independent: `ch` selects the state slice.

## Timing
- Edge detection: `edge_pulse` occurs 2–3 `clk` cycles after the `l_r_clk` transition.
- Busy window: `busy` is high from E+1 through E+19. Each section is 6 cycles, giving 18 cycles for three sections, plus the DONE cycle.
- Output: `sample_out` updates and `out_valid` pulses in cycle E+19.
- Throughput: the minimum accepted edge spacing is 20 `clk` cycles.
- Reset values:
  - `sample_out` = 0, `sample_out_ch` = 0;
  - `out_valid`, `busy` and `overrun` = 0;
  - all x/y state = 0;
  - state machine = IDLE, commit-pending bit = 0;
  - shadow and active banks: b0 = 0x4000, all other taps = 0x0000 (unity passthrough).
- Reset mid-sample aborts processing immediately; no `out_valid` pulse is produced for the aborted sample.
- `overrun` clears only on reset.

## Structure
- Package `eq_pkg` holds:
  - DATA_W, COEF_W, FRAC_BITS=14, N_SECT, N_TAPS=5;
  - tap index constants;
  - state enum {IDLE, MAC, WB, DONE};
  - coefficient reset constants;
  - `sat16` function.
- Sub-module `eq_coef_bank` holds the shadow bank, active bank, commit-pending logic and the read mux addressed by (s, t).
- The scheduler holds the synchronizer, FSM, MAC and state arrays [2][N_SECT].

## Test plan
1. **Reset passthrough:** after reset, edge with `sample_in`=0x1234 → `sample_out`=0x1234 at E+19, `out_valid` high exactly one cycle, `busy` high E+1..E+19.
2. **Commit:** write section 0 b0=0x2000, then commit, then edge with 0x4000 → 0x2000. A write made without a commit has no effect on the next sample.
3. **Recursion and channel isolation:** section 0 a1=0x2000; left-channel impulse 0x1000, then zeros → left outputs 0x1000, 0x0800, 0x0400. Interleaved right-channel samples of 0 → right outputs 0.
4. **Saturation:** b0=0x7FFF in all three sections; input 0x7FFF → 0x7FFF; input 0x8000 → 0x8000.
5. **Overrun:** second `l_r_clk` toggle 10 cycles after the first → second edge dropped, `overrun`=1, exactly one `out_valid` pulse.
6. **Deferred commit and reset abort:** commit at E+5 → the current sample uses old coefficients and the next sample uses new ones. Reset asserted at E+8 → `sample_out`=0, no `out_valid` pulse, coefficients back to passthrough.
